// File: rtl/icap_axi_loader.sv
// icap_axi_loader
//   AXI4-Lite master that streams partial-reconfiguration words into an AXI
//   HWICAP core. Words arrive on a valid/ready stream, are written one at a
//   time to the write FIFO (WF), and after each burst the ICAP write is
//   kicked through CR and SR is polled until DONE.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start
//   LOAD   | accepting one bitstream word (s_word_tready=1)
//   AW_W   | AW and W in flight; each valid drops after its own handshake
//   RESP   | waiting for the write response
//   POLL   | read address to SR in flight
//   RDATA  | waiting for the SR read data
//   DONE   | one-cycle completion pulse
//   ERR    | one-cycle error exit (err stays set until next start)
//
// Ports
//   clk, rst_n            clock (shared with s_axi_aclk), async active-low reset
//   start                 one-cycle pulse that begins a load when not busy
//   busy, done            load in progress / one-cycle success pulse
//   err, err_code         sticky error flag; 01 bresp, 10 rresp, 11 timeout
//   word_cnt              words successfully written to WF in this load
//   s_word_*              32-bit bitstream word stream with tlast
//   m_axi_*               AXI4-Lite master towards the HWICAP
module icap_axi_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned BURST_WORDS = 64,
    parameter logic [15:0] POLL_MAX    = 16'd1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] word_cnt,
    input  logic [31:0] s_word_tdata,
    input  logic        s_word_tvalid,
    output logic        s_word_tready,
    input  logic        s_word_tlast,
    output logic [31:0] m_axi_awaddr,
    output logic [2:0]  m_axi_awprot,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_AW_W, S_RESP, S_POLL, S_RDATA, S_DONE, S_ERR
    } state_t;

    localparam logic [31:0] ADDR_WF    = BASE_ADDR + 32'h100;
    localparam logic [31:0] ADDR_CR    = BASE_ADDR + 32'h10C;
    localparam logic [31:0] ADDR_SR    = BASE_ADDR + 32'h110;
    localparam logic [10:0] BURST_LAST = 11'(BURST_WORDS);

    state_t      r_state, w_next;
    logic [31:0] r_wdata;
    logic        r_is_cr;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_last_seen;
    logic [10:0] r_burst_cnt;
    logic [15:0] r_poll_cnt;
    logic [15:0] r_word_cnt;
    logic        r_err;
    logic [1:0]  r_err_code;

    logic        w_aw_ok, w_w_ok, w_burst_end, w_poll_end;
    logic [10:0] w_burst_inc;
    logic [15:0] w_poll_inc;
    logic        w_unused_rdata;

    // A channel counts as finished once its valid has dropped or is being
    // accepted this cycle.
    assign w_aw_ok     = !r_awvalid || m_axi_awready;
    assign w_w_ok      = !r_wvalid  || m_axi_wready;
    assign w_burst_inc = r_burst_cnt + 11'd1;
    assign w_burst_end = (w_burst_inc == BURST_LAST) || r_last_seen;
    assign w_poll_inc  = r_poll_cnt + 16'd1;
    assign w_poll_end  = (w_poll_inc == POLL_MAX);
    assign w_unused_rdata = ^m_axi_rdata[31:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  if (s_word_tvalid) w_next = S_AW_W;
            S_AW_W:  if (w_aw_ok && w_w_ok) w_next = S_RESP;
            S_RESP: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) w_next = S_ERR;
                    else if (!r_is_cr)        w_next = w_burst_end ? S_AW_W : S_LOAD;
                    else                      w_next = S_POLL;
                end
            end
            S_POLL:  if (m_axi_arready) w_next = S_RDATA;
            S_RDATA: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rresp != 2'b00) w_next = S_ERR;
                    else if (m_axi_rdata[0])  w_next = r_last_seen ? S_DONE : S_LOAD;
                    else                      w_next = w_poll_end ? S_ERR : S_POLL;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdata     <= '0;
            r_is_cr     <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_last_seen <= 1'b0;
            r_burst_cnt <= '0;
            r_poll_cnt  <= '0;
            r_word_cnt  <= '0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err       <= 1'b0;
                        r_err_code  <= 2'b00;
                        r_word_cnt  <= '0;
                        r_burst_cnt <= '0;
                        r_last_seen <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (s_word_tvalid) begin
                        r_wdata     <= s_word_tdata;
                        r_last_seen <= s_word_tlast;
                        r_is_cr     <= 1'b0;
                        r_awvalid   <= 1'b1;
                        r_wvalid    <= 1'b1;
                    end
                end
                S_AW_W: begin
                    if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
                    if (r_wvalid  && m_axi_wready)  r_wvalid  <= 1'b0;
                end
                S_RESP: begin
                    if (m_axi_bvalid) begin
                        if (m_axi_bresp != 2'b00) begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'b01;
                        end else if (!r_is_cr) begin
                            r_word_cnt  <= r_word_cnt + 16'd1;
                            r_burst_cnt <= w_burst_inc;
                            if (w_burst_end) begin
                                // Kick the ICAP: write the Write bit to CR.
                                r_is_cr   <= 1'b1;
                                r_wdata   <= 32'h1;
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                            end
                        end else begin
                            r_poll_cnt <= '0;
                        end
                    end
                end
                S_RDATA: begin
                    if (m_axi_rvalid) begin
                        if (m_axi_rresp != 2'b00) begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'b10;
                        end else if (m_axi_rdata[0]) begin
                            r_burst_cnt <= '0;
                        end else begin
                            r_poll_cnt <= w_poll_inc;
                            if (w_poll_end) begin
                                r_err      <= 1'b1;
                                r_err_code <= 2'b11;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
    assign done          = (r_state == S_DONE);
    assign err           = r_err;
    assign err_code      = r_err_code;
    assign word_cnt      = r_word_cnt;
    assign s_word_tready = (r_state == S_LOAD);

    // Addresses are forced to zero while idle so every output reads 0 in reset.
    assign m_axi_awaddr  = r_awvalid ? (r_is_cr ? ADDR_CR : ADDR_WF) : 32'h0;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = (r_state == S_RESP);
    assign m_axi_araddr  = (r_state == S_POLL) ? ADDR_SR : 32'h0;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (r_state == S_POLL);
    assign m_axi_rready  = (r_state == S_RDATA);

endmodule

// File: tb/tb_icap_axi_loader.sv
module tb_icap_axi_loader;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam int          BW   = 4;
    localparam int          PM   = 5;
    localparam logic [31:0] A_WF = BASE + 32'h100;
    localparam logic [31:0] A_CR = BASE + 32'h10C;
    localparam logic [31:0] A_SR = BASE + 32'h110;

    logic        clk, rst_n, start, busy, done, err;
    logic [1:0]  err_code;
    logic [15:0] word_cnt;
    logic [31:0] s_tdata;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    icap_axi_loader #(.BASE_ADDR(BASE), .BURST_WORDS(BW), .POLL_MAX(16'(PM))) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .err(err), .err_code(err_code), .word_cnt(word_cnt),
        .s_word_tdata(s_tdata), .s_word_tvalid(s_tvalid),
        .s_word_tready(s_tready), .s_word_tlast(s_tlast),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    int          total = 0, bad = 0;
    logic [31:0] words[$];
    bit          sr_q[$];
    bit          sr_default = 1'b1;
    int          bresp_err_at = 0, rresp_err_at = 0, hold_b_at = 0;
    bit          stalls = 1'b0;
    int          done_cnt = 0;
    int          exp_done, exp_wc;
    logic [1:0]  exp_code;
    int          f_idx, f_n;
    bit          f_acc;

    // slave state
    bit          aw_got, w_got, ar_got, b_hs, r_hs, pair_new;
    bit          aw_st, w_st, ar_st;
    logic [31:0] aw_addr_c, w_data_c, aw_st_addr, w_st_data, rnd;
    int          slv_wr_idx, slv_rd_idx;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic void push_txn(input bit rd, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.is_rd = rd;
        t.addr  = a;
        t.data  = d;
        exp_q.push_back(t);
    endfunction

    // Reference: the transaction list a load must produce, from the load rules.
    function automatic void build_model(input int n);
        bit sq[$];
        int wr, rd, burst;
        bit v;
        sq = sr_q;
        wr = 0; rd = 0; burst = 0;
        exp_q.delete();
        exp_wc = 0; exp_code = 2'b00; exp_done = 0;
        for (int i = 0; i < n; i++) begin
            wr++;
            push_txn(1'b0, A_WF, words[i]);
            if (wr == bresp_err_at) begin exp_code = 2'b01; return; end
            exp_wc++;
            burst++;
            if (burst == BW || i == n - 1) begin
                wr++;
                push_txn(1'b0, A_CR, 32'h1);
                if (wr == bresp_err_at) begin exp_code = 2'b01; return; end
                for (int p = 1; p <= PM; p++) begin
                    rd++;
                    push_txn(1'b1, A_SR, 32'h0);
                    if (rd == rresp_err_at) begin exp_code = 2'b10; return; end
                    v = (sq.size() > 0) ? sq.pop_front() : sr_default;
                    if (v) break;
                    if (p == PM) begin exp_code = 2'b11; return; end
                end
                burst = 0;
            end
        end
        exp_done = 1;
    endfunction

    // AXI slave + monitor: readies/valids change on the falling edge, and the
    // handshakes for the coming rising edge are evaluated 1 time unit later.
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rdata = 0; rresp = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_hs = 0; r_hs = 0;
                aw_st = 0; w_st = 0; ar_st = 0;
                slv_wr_idx = 0; slv_rd_idx = 0;
                continue;
            end
            if (b_hs) begin bvalid = 0; bresp = 0; b_hs = 0; end
            if (r_hs) begin rvalid = 0; rresp = 0; r_hs = 0; end
            if (aw_got && w_got && !bvalid && slv_wr_idx != hold_b_at &&
                (!stalls || $urandom_range(0, 2) == 0)) begin
                bvalid = 1;
                bresp  = (slv_wr_idx == bresp_err_at) ? 2'b10 : 2'b00;
                aw_got = 0; w_got = 0;
            end
            if (ar_got && !rvalid && (!stalls || $urandom_range(0, 2) == 0)) begin
                rnd = $urandom;
                slv_rd_idx++;
                rresp = (slv_rd_idx == rresp_err_at) ? 2'b10 : 2'b00;
                rnd[0] = (sr_q.size() > 0) ? sr_q.pop_front() : sr_default;
                rdata  = rnd;
                rvalid = 1;
                ar_got = 0;
            end
            awready = !stalls || ($urandom_range(0, 1) == 1);
            wready  = !stalls || ($urandom_range(0, 1) == 1);
            arready = !stalls || ($urandom_range(0, 1) == 1);
            #1;
            if (aw_st) chk("awvalid_held", {awvalid, awaddr}, {1'b1, aw_st_addr});
            if (w_st)  chk("wvalid_held", {wvalid, wdata}, {1'b1, w_st_data});
            if (ar_st) chk("arvalid_held", {arvalid, araddr}, {1'b1, A_SR});
            aw_st = awvalid && !awready; aw_st_addr = awaddr;
            w_st  = wvalid && !wready;   w_st_data  = wdata;
            ar_st = arvalid && !arready;
            pair_new = 0;
            if (awvalid && awready) begin aw_got = 1; aw_addr_c = awaddr; pair_new = 1; end
            if (wvalid && wready)   begin w_got = 1;  w_data_c = wdata;   pair_new = 1; end
            if (pair_new && aw_got && w_got) begin
                slv_wr_idx++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, none expected", aw_addr_c, w_data_c);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    chk("write_txn", {1'b0, aw_addr_c, w_data_c}, {t.is_rd, t.addr, t.data});
                end
            end
            if (bvalid && bready) b_hs = 1;
            if (arvalid && arready) begin
                ar_got = 1;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_read: got addr %0h, none expected", araddr);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    chk("read_txn", {1'b1, araddr}, {t.is_rd, t.addr});
                end
            end
            if (rvalid && rready) r_hs = 1;
        end
    end

    task automatic feed_step();
        if (f_acc) begin f_idx++; s_tvalid = 0; s_tlast = 0; f_acc = 0; end
        if (!s_tvalid && f_idx < f_n && (!stalls || $urandom_range(0, 2) != 0)) begin
            s_tvalid = 1;
            s_tdata  = words[f_idx];
            s_tlast  = (f_idx == f_n - 1);
        end
        if (s_tvalid && s_tready) f_acc = 1;
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic begin_load(input int n);
        build_model(n);
        done_cnt = 0; slv_wr_idx = 0; slv_rd_idx = 0;
        f_idx = 0; f_n = n; f_acc = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", {busy, err, err_code, word_cnt}, {1'b1, 1'b0, 2'b00, 16'h0});
    endtask

    task automatic run_test(input string name, input int n);
        bit finished;
        begin_load(n);
        finished = 0;
        for (int c = 0; c < 4000; c++) begin
            feed_step();
            if (done === 1'b1 || err === 1'b1) begin finished = 1; break; end
            @(negedge clk);
        end
        if (!finished) begin
            total++; bad++;
            $display("FAIL %s_timeout: no done or err within cycle budget", name);
        end
        s_tvalid = 0; s_tlast = 0;
        repeat (4) @(negedge clk);
        chk({name, "_done_pulses"}, done_cnt, exp_done);
        chk({name, "_status"}, {busy, err, err_code}, {1'b0, exp_code != 2'b00, exp_code});
        chk({name, "_word_cnt"}, word_cnt, exp_wc[15:0]);
        chk({name, "_txns_left"}, exp_q.size(), 0);
        if (exp_done != 0) chk({name, "_words_taken"}, f_idx, n);
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctrl"}, {busy, done, err, err_code, word_cnt, s_tready}, 0);
        chk({name, "_valids"}, {awvalid, wvalid, bready, arvalid, rready}, 0);
        chk({name, "_payload"}, {awaddr, wdata, araddr}, 0);
    endtask

    initial begin
        bit reached;
        rst_n = 0; start = 0; s_tvalid = 0; s_tdata = 0; s_tlast = 0;
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        fill_words(4);  run_test("four_words", 4);

        stalls = 1;
        fill_words(10); run_test("ten_words", 10);
        fill_words(1);  run_test("one_word", 1);

        sr_q = '{1'b0, 1'b0, 1'b0};
        fill_words(6);  run_test("slow_done", 6);

        sr_default = 0;
        fill_words(3);  run_test("poll_timeout", 3);
        sr_default = 1;

        bresp_err_at = 2;
        fill_words(5);  run_test("bresp_err", 5);
        bresp_err_at = 0;

        rresp_err_at = 1;
        fill_words(2);  run_test("rresp_err", 2);
        rresp_err_at = 0;

        for (int k = 0; k < 4; k++) begin
            sr_q.delete();
            for (int z = $urandom_range(0, 3); z > 0; z--) sr_q.push_back(1'b0);
            fill_words($urandom_range(1, 12));
            run_test("random", words.size());
        end

        // Reset asserted while waiting on the second write response.
        sr_q.delete();
        hold_b_at = 2;
        fill_words(6);
        begin_load(6);
        reached = 0;
        for (int c = 0; c < 4000; c++) begin
            feed_step();
            if (bready === 1'b1 && slv_wr_idx == 2) begin reached = 1; break; end
            @(negedge clk);
        end
        if (!reached) begin
            total++; bad++;
            $display("FAIL reset_setup: second write response never awaited");
        end
        repeat (2) @(negedge clk);
        chk("pre_reset_state", {bready, busy, word_cnt}, {1'b1, 1'b1, 16'd1});
        #2 rst_n = 0;
        #1 check_zero("mid_resp_reset");
        s_tvalid = 0; s_tlast = 0; hold_b_at = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        exp_q.delete();
        repeat (2) @(negedge clk);

        fill_words(5);  run_test("after_reset", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
